// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, immediate kinds, ID/EX record.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU codes are {funct7[5], funct3}; only the two forced by decode are named.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  // Everything the execute stage receives; an all-zero value is a bubble.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic              pc_src;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              branch;
    logic              jump;
    logic              illegal;
  } idex_t;

  // Sign-extended immediate for the given encoding format.
  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr, input imm_type_e kind);
    logic [XLEN-1:0] imm;
    case (kind)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file, two read ports and one write port, x0 reads as zero.
// Latency: reads combinational with same-cycle write-through; write lands on the rising edge.
// Backpressure: none, a write is accepted every cycle it is enabled.
module regfile_2r1w #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic             wr_en;

  assign wr_en = we && (waddr != '0);

  // Register array: cleared asynchronously, writes to x0 dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 1: x0 is zero, a same-cycle write to the read index is forwarded.
  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == '0)                    rdata1 = '0;
    else if (wr_en && waddr == raddr1)   rdata1 = wdata;
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == '0)                    rdata2 = '0;
    else if (wr_en && waddr == raddr2)   rdata2 = wdata;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode: control decode, register read, immediate build, load-use hazard, ID/EX register.
// Latency: one cycle from decode inputs to ex_* outputs; stall_o is combinational.
// Backpressure: raises stall_o for one cycle on a load-use pair and inserts a bubble meanwhile.
module id_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           id_pc_i,
  input  logic [31:0]           id_instr_i,
  input  logic                  flush,
  input  logic                  wb_we_i,
  input  logic [4:0]            wb_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  stall_o,
  output logic [31:0]           ex_pc_o,
  output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
  output logic [31:0]           ex_imm_o,
  output logic [4:0]            ex_rs1_o,
  output logic [4:0]            ex_rs2_o,
  output logic [4:0]            ex_rd_o,
  output logic [2:0]            ex_funct3_o,
  output logic [3:0]            ex_alu_op_o,
  output logic                  ex_alu_src_o,
  output logic                  ex_pc_src_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o,
  output logic                  ex_illegal_o
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [4:0]            rs1_idx, rs2_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rf_rs1_data, rf_rs2_data;
  logic                  rs1_used, rs2_used, rd_used, known;
  logic                  hazard;
  imm_type_e             imm_type;
  idex_t                 dec, idex_q;

  assign opcode  = id_instr_i[6:0];
  assign funct3  = id_instr_i[14:12];
  assign rs1_idx = id_instr_i[19:15];
  assign rs2_idx = id_instr_i[24:20];
  assign rd_idx  = id_instr_i[11:7];

  regfile_2r1w #(
    .WIDTH    (DATA_WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we_i),
    .waddr  (wb_rd_i),
    .wdata  (wb_data_i),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rf_rs1_data),
    .rdata2 (rf_rs2_data)
  );

  // Decode the instruction into the ID/EX record; unknown non-zero words flag illegal only.
  always_comb begin
    dec      = '0;
    imm_type = IMM_NONE;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    rd_used  = 1'b0;
    known    = 1'b1;
    case (opcode)
      OPC_LUI: begin
        imm_type = IMM_U; rd_used = 1'b1;
        dec.reg_write = 1'b1; dec.alu_src = 1'b1;
      end
      OPC_AUIPC: begin
        imm_type = IMM_U; rd_used = 1'b1;
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.pc_src = 1'b1;
      end
      OPC_JAL: begin
        imm_type = IMM_J; rd_used = 1'b1;
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_src = 1'b1; dec.pc_src = 1'b1;
      end
      OPC_JALR: begin
        imm_type = IMM_I; rs1_used = 1'b1; rd_used = 1'b1;
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_src = 1'b1;
      end
      OPC_BRANCH: begin
        imm_type = IMM_B; rs1_used = 1'b1; rs2_used = 1'b1;
        dec.branch = 1'b1; dec.alu_op = ALU_SUB;
      end
      OPC_LOAD: begin
        imm_type = IMM_I; rs1_used = 1'b1; rd_used = 1'b1;
        dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
      end
      OPC_STORE: begin
        imm_type = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1;
        dec.mem_write = 1'b1; dec.alu_src = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_type = IMM_I; rs1_used = 1'b1; rd_used = 1'b1;
        dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        // instr[30] is part of the immediate except for the SRLI/SRAI selector.
        dec.alu_op = {(funct3 == 3'b101) ? id_instr_i[30] : 1'b0, funct3};
      end
      OPC_OP: begin
        rs1_used = 1'b1; rs2_used = 1'b1; rd_used = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op = {id_instr_i[30], funct3};
      end
      default: begin
        known       = 1'b0;
        dec.illegal = (id_instr_i != 32'h0);
      end
    endcase
    dec.pc       = id_pc_i;
    dec.imm      = gen_imm(id_instr_i, imm_type);
    dec.funct3   = known ? funct3 : 3'b0;
    dec.rs1      = rs1_used ? rs1_idx : 5'd0;
    dec.rs2      = rs2_used ? rs2_idx : 5'd0;
    dec.rd       = rd_used ? rd_idx : 5'd0;
    dec.rs1_data = (opcode == OPC_LUI) ? '0 : rf_rs1_data;
    dec.rs2_data = rf_rs2_data;
  end

  // Load-use hazard: the load now in EX writes a register this instruction reads.
  always_comb begin
    hazard = idex_q.mem_read && (idex_q.rd != 5'd0) &&
             ((rs1_used && rs1_idx == idex_q.rd) || (rs2_used && rs2_idx == idex_q.rd));
  end

  // A redirect makes the stall pointless, so flush suppresses it.
  assign stall_o = hazard && !flush;

  // ID/EX pipeline register: bubble on flush or hazard, otherwise the decoded instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  idex_q <= '0;
    else if (flush || hazard) idex_q <= '0;
    else                      idex_q <= dec;
  end

  assign ex_pc_o        = idex_q.pc;
  assign ex_rs1_data_o  = idex_q.rs1_data;
  assign ex_rs2_data_o  = idex_q.rs2_data;
  assign ex_imm_o       = idex_q.imm;
  assign ex_rs1_o       = idex_q.rs1;
  assign ex_rs2_o       = idex_q.rs2;
  assign ex_rd_o        = idex_q.rd;
  assign ex_funct3_o    = idex_q.funct3;
  assign ex_alu_op_o    = idex_q.alu_op;
  assign ex_alu_src_o   = idex_q.alu_src;
  assign ex_pc_src_o    = idex_q.pc_src;
  assign ex_mem_read_o  = idex_q.mem_read;
  assign ex_mem_write_o = idex_q.mem_write;
  assign ex_reg_write_o = idex_q.reg_write;
  assign ex_branch_o    = idex_q.branch;
  assign ex_jump_o      = idex_q.jump;
  assign ex_illegal_o   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: scoreboard of expected ID/EX contents per driven instruction.
// Latency: expects each decoded instruction on the ex_* outputs one rising edge after it is driven.
// Backpressure: the bench plays the fetch stage and holds the instruction while stall_o is high.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc_i, id_instr_i;
  logic        flush, wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        stall_o;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic [3:0]  ex_alu_op_o;
  logic        ex_alu_src_o, ex_pc_src_o, ex_mem_read_o, ex_mem_write_o;
  logic        ex_reg_write_o, ex_branch_o, ex_jump_o, ex_illegal_o;

  always #5 clk = ~clk;

  id_stage #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .id_pc_i(id_pc_i), .id_instr_i(id_instr_i), .flush(flush),
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .stall_o(stall_o),
    .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_funct3_o(ex_funct3_o), .ex_alu_op_o(ex_alu_op_o), .ex_alu_src_o(ex_alu_src_o),
    .ex_pc_src_o(ex_pc_src_o), .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o),
    .ex_illegal_o(ex_illegal_o)
  );

  // ctl bits: {alu_src, pc_src, mem_read, mem_write, reg_write, branch, jump, illegal}
  typedef struct packed {
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  r1, r2, rd;
    logic [2:0]  f3;
    logic [3:0]  op;
    logic [7:0]  ctl;
  } obs_t;

  localparam logic [7:0] C_SRC = 8'h80, C_PC = 8'h40, C_MR = 8'h20, C_MW = 8'h10;
  localparam logic [7:0] C_RW  = 8'h08, C_BR = 8'h04, C_J  = 8'h02, C_ILL = 8'h01;

  obs_t obs, exp_v;
  obs_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;

  assign obs = {ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
                ex_funct3_o, ex_alu_op_o,
                {ex_alu_src_o, ex_pc_src_o, ex_mem_read_o, ex_mem_write_o,
                 ex_reg_write_o, ex_branch_o, ex_jump_o, ex_illegal_o}};

  function automatic obs_t mk(input logic [31:0] pc, r1d, r2d, imm, input logic [4:0] r1, r2, rd,
                              input logic [2:0] f3, input logic [3:0] op, input logic [7:0] ctl);
    obs_t o;
    o = {pc, r1d, r2d, imm, r1, r2, rd, f3, op, ctl};
    return o;
  endfunction

  // Fetch-side driver: apply one decode cycle and queue what EX must show after the edge.
  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic fl,
                       input logic we, input logic [4:0] rd, input logic [31:0] data,
                       input obs_t e);
    @(negedge clk);
    id_pc_i = pc; id_instr_i = instr; flush = fl;
    wb_we_i = we; wb_rd_i = rd; wb_data_i = data;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; id_pc_i = '0; id_instr_i = '0; flush = 1'b0;
    wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (obs !== '0) begin n_err++; $display("FAIL reset_state got=%h exp=0", obs); end
    n_chk++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    @(negedge clk); rst = 1'b0;
    // write x5 alongside a bubble, then read it back
    drive(32'h10, 32'h0, 1'b0, 1'b1, 5'd5, 32'h55, mk(32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1; exp_v = sb.pop_front();
    n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL wr_x5 got=%h exp=%h", obs, exp_v); end
    drive(32'h14, 32'h000283B3, 1'b0, 1'b0, 5'd0, 32'h0, mk(32'h14, 32'h55, 0, 0, 5, 0, 7, 0, 0, C_RW));
    @(posedge clk); #1; exp_v = sb.pop_front();
    n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL rd_x5 got=%h exp=%h", obs, exp_v); end
    // asynchronous reset in the middle of a cycle
    @(negedge clk); #2 rst = 1'b1; #1;
    n_chk++; if (obs !== '0) begin n_err++; $display("FAIL async_rst got=%h exp=0", obs); end
    n_chk++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL async_rst_stall got=%b exp=0", stall_o); end
    @(negedge clk); rst = 1'b0;
    drive(32'h18, 32'h000283B3, 1'b0, 1'b0, 5'd0, 32'h0, mk(32'h18, 0, 0, 0, 5, 0, 7, 0, 0, C_RW));
    @(posedge clk); #1; exp_v = sb.pop_front();
    n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL x5_cleared got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_op_imm();
    logic [31:0] ins [3];
    obs_t        ex  [3];
    ins = '{32'h00500093, 32'h4030D113, 32'hFFF0C113};
    ex  = '{mk(32'h100, 0, 0, 32'd5,        0, 0, 1, 3'd0, 4'b0000, C_SRC | C_RW),   // addi x1,x0,5
            mk(32'h104, 0, 0, 32'h403,      1, 0, 2, 3'd5, 4'b1101, C_SRC | C_RW),   // srai x2,x1,3
            mk(32'h108, 0, 0, 32'hFFFFFFFF, 1, 0, 2, 3'd4, 4'b0100, C_SRC | C_RW)};  // xori x2,x1,-1
    for (int i = 0; i < 3; i++) begin
      drive(32'h100 + 4 * i, ins[i], 1'b0, 1'b0, 5'd0, 32'h0, ex[i]);
      @(posedge clk); #1; exp_v = sb.pop_front();
      n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL op_imm[%0d] got=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] ins [5], dat [5];
    logic        we  [5];
    logic [4:0]  rd  [5];
    obs_t        ex  [5];
    ins = '{32'h00018233, 32'h00018233, 32'h40318233, 32'h00000233, 32'h00000233};
    we  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    rd  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0};
    dat = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h1234, 32'h0};
    ex  = '{mk(32'h200, 32'hDEADBEEF, 0, 0, 3, 0, 4, 0, 4'b0000, C_RW),            // write-through
            mk(32'h204, 32'hDEADBEEF, 0, 0, 3, 0, 4, 0, 4'b0000, C_RW),            // stored value
            mk(32'h208, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 3, 4, 0, 4'b1000, C_RW), // sub x4,x3,x3
            mk(32'h20C, 0, 0, 0, 0, 0, 4, 0, 4'b0000, C_RW),                       // x0 write ignored
            mk(32'h210, 0, 0, 0, 0, 0, 4, 0, 4'b0000, C_RW)};
    for (int i = 0; i < 5; i++) begin
      drive(32'h200 + 4 * i, ins[i], 1'b0, we[i], rd[i], dat[i], ex[i]);
      @(posedge clk); #1; exp_v = sb.pop_front();
      n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL bypass[%0d] got=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  task automatic test_load_use();
    drive(32'h300, 32'h0000A283, 1'b0, 1'b0, 5'd0, 32'h0, mk(32'h300, 0, 0, 0, 1, 0, 5, 3'd2, 0, C_SRC | C_MR | C_RW));
    #1; n_chk++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_no_stall got=%b exp=0", stall_o); end
    @(posedge clk); #1; exp_v = sb.pop_front();
    n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL lu_load got=%h exp=%h", obs, exp_v); end
    drive(32'h304, 32'h00528333, 1'b0, 1'b0, 5'd0, 32'h0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1; n_chk++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL lu_stall got=%b exp=1", stall_o); end
    @(posedge clk); #1; exp_v = sb.pop_front();
    n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL lu_bubble got=%h exp=%h", obs, exp_v); end
    drive(32'h304, 32'h00528333, 1'b0, 1'b0, 5'd0, 32'h0, mk(32'h304, 0, 0, 0, 5, 5, 6, 0, 0, C_RW));
    #1; n_chk++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL lu_stall_clear got=%b exp=0", stall_o); end
    @(posedge clk); #1; exp_v = sb.pop_front();
    n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL lu_issue got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_flush_hazard();
    drive(32'h400, 32'h0000A283, 1'b0, 1'b0, 5'd0, 32'h0, mk(32'h400, 0, 0, 0, 1, 0, 5, 3'd2, 0, C_SRC | C_MR | C_RW));
    @(posedge clk); #1; exp_v = sb.pop_front();
    n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL fl_load got=%h exp=%h", obs, exp_v); end
    drive(32'h404, 32'h00528333, 1'b1, 1'b0, 5'd0, 32'h0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1; n_chk++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL fl_stall got=%b exp=0", stall_o); end
    @(posedge clk); #1; exp_v = sb.pop_front();
    n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL fl_bubble got=%h exp=%h", obs, exp_v); end
    drive(32'h500, 32'h00500093, 1'b0, 1'b0, 5'd0, 32'h0, mk(32'h500, 0, 0, 32'd5, 0, 0, 1, 0, 0, C_SRC | C_RW));
    @(posedge clk); #1; exp_v = sb.pop_front();
    n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL fl_target got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_decode_edges();
    logic [31:0] ins [7];
    obs_t        ex  [7];
    ins = '{32'hFFFFFFFF, 32'h00000000, 32'hFE208EE3, 32'h80018437,
            32'hFE312C23, 32'hFFDFF0EF, 32'h00001117};
    ex  = '{mk(32'h600, 0, 0, 0, 0, 0, 0, 0, 0, C_ILL),                                   // illegal
            mk(32'h604, 0, 0, 0, 0, 0, 0, 0, 0, 0),                                       // bubble
            mk(32'h608, 0, 0, 32'hFFFFFFFC, 1, 2, 0, 3'd0, 4'b1000, C_BR),                 // beq x1,x2,-4
            mk(32'h60C, 0, 0, 32'h80018000, 0, 0, 8, 3'd0, 4'b0000, C_SRC | C_RW),         // lui, rs1 field = x3
            mk(32'h610, 0, 32'hDEADBEEF, 32'hFFFFFFF8, 2, 3, 0, 3'd2, 0, C_SRC | C_MW),    // sw x3,-8(x2)
            mk(32'h614, 0, 0, 32'hFFFFFFFC, 0, 0, 1, 3'd7, 0, C_SRC | C_PC | C_RW | C_J),  // jal x1,-4
            mk(32'h618, 0, 0, 32'h00001000, 0, 0, 2, 3'd1, 0, C_SRC | C_PC | C_RW)};       // auipc x2,1
    for (int i = 0; i < 7; i++) begin
      drive(32'h600 + 4 * i, ins[i], 1'b0, 1'b0, 5'd0, 32'h0, ex[i]);
      @(posedge clk); #1; exp_v = sb.pop_front();
      n_chk++; if (obs !== exp_v) begin n_err++; $display("FAIL decode[%0d] got=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_op_imm();
    test_bypass();
    test_load_use();
    test_flush_hazard();
    test_decode_edges();
    n_chk++;
    if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
